// File: rtl/fm_phase_mux.sv
// fm_phase_mux: selects a phase-increment word per accepted beat (constant
// carrier, offset-binary passthrough or carrier + scaled signed signal) and
// presents it through a 2-entry skid buffer. All outputs come straight from
// registers, so the master-side ready has no combinational path to the
// slave-side ready. Samples arriving in carrier mode are counted and dropped.
module fm_phase_mux #(
    parameter int CARRIER_PINC_WIDTH = 32,
    parameter int SIGNAL_PHASE_WIDTH = 16,
    parameter int S_AXIS_TDATA_WIDTH = 16,
    parameter int M_AXIS_TDATA_WIDTH = 32,
    parameter int SHIFT_WIDTH        = 5,
    parameter int DROP_COUNT_WIDTH   = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [1:0]                    mode,
    input  logic [CARRIER_PINC_WIDTH-1:0] phase_carrier,
    input  logic [SHIFT_WIDTH-1:0]        dev_shift,
    input  logic                          S_AXIS_tvalid,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                          S_AXIS_tready,
    input  logic                          M_AXIS_tready,
    output logic                          M_AXIS_tvalid,
    output logic [M_AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic [DROP_COUNT_WIDTH-1:0]   drop_count
);

    localparam int M_W  = M_AXIS_TDATA_WIDTH;
    localparam int SP_W = SIGNAL_PHASE_WIDTH;
    localparam int SH_W = (M_W > 1) ? $clog2(M_W) : 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

    buf_state_t                  state_r;
    buf_state_t                  state_next_s;
    logic [M_W-1:0]              head_r;
    logic [M_W-1:0]              skid_r;
    logic                        m_valid_r;
    logic                        s_ready_r;
    logic [DROP_COUNT_WIDTH-1:0] drop_count_r;

    logic [SP_W-1:0] sig_raw_s;
    logic [SP_W-1:0] pass_raw_s;
    logic [M_W-1:0]  carrier_ext_s;
    logic [M_W-1:0]  sig_ext_s;
    logic [M_W-1:0]  beat_word_s;
    logic [SH_W-1:0] shift_amt_s;
    logic            carrier_sel_s;
    logic            pass_sel_s;
    logic            full_s;
    logic            s_hs_s;
    logic            gen_fire_s;
    logic            data_fire_s;
    logic            in_fire_s;
    logic            out_fire_s;
    logic            drop_s;

    assign sig_raw_s = S_AXIS_tdata[SP_W-1:0];

    // Decode the source mode; the reserved encoding behaves as carrier.
    always_comb begin
        carrier_sel_s = 1'b1;
        pass_sel_s    = 1'b0;
        case (mode)
            2'd1: begin
                carrier_sel_s = 1'b0;
                pass_sel_s    = 1'b1;
            end
            2'd2: begin
                carrier_sel_s = 1'b0;
                pass_sel_s    = 1'b0;
            end
            default: begin
                carrier_sel_s = 1'b1;
                pass_sel_s    = 1'b0;
            end
        endcase
    end

    // Build the phase word for a beat entering this cycle from the live config.
    always_comb begin
        carrier_ext_s = M_W'(phase_carrier);
        sig_ext_s     = M_W'($signed(sig_raw_s));
        // Adding half scale modulo 2^SP_W is just an MSB flip.
        pass_raw_s    = {~sig_raw_s[SP_W-1], sig_raw_s[SP_W-2:0]};
        if (32'(dev_shift) > 32'(M_W - 1)) begin
            shift_amt_s = SH_W'(M_W - 1);
        end else begin
            shift_amt_s = SH_W'(dev_shift);
        end
        if (carrier_sel_s) begin
            beat_word_s = carrier_ext_s;
        end else if (pass_sel_s) begin
            beat_word_s = M_W'(pass_raw_s);
        end else begin
            // Wraps modulo 2^M_W by construction.
            beat_word_s = carrier_ext_s + (sig_ext_s << shift_amt_s);
        end
    end

    // Handshake qualification and next buffer occupancy.
    always_comb begin
        full_s      = (state_r == ST_FULL);
        out_fire_s  = m_valid_r & M_AXIS_tready;
        s_hs_s      = S_AXIS_tvalid & s_ready_r;
        // s_ready_r doubles as the "out of reset" enable for the carrier generator.
        gen_fire_s  = carrier_sel_s & s_ready_r & ~full_s;
        data_fire_s = ~carrier_sel_s & s_hs_s & ~full_s;
        in_fire_s   = gen_fire_s | data_fire_s;
        // A ready-qualified sample that cannot be buffered is discarded and counted.
        drop_s      = s_hs_s & (carrier_sel_s | full_s);
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (in_fire_s) begin
                    state_next_s = ST_ONE;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_fire_s && !out_fire_s) begin
                    state_next_s = ST_FULL;
                end else if (!in_fire_s && out_fire_s) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (out_fire_s) begin
                    state_next_s = ST_ONE;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // Buffer state, head/skid data, registered handshakes and the drop counter.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r      <= ST_EMPTY;
            head_r       <= {M_W{1'b0}};
            skid_r       <= {M_W{1'b0}};
            m_valid_r    <= 1'b0;
            s_ready_r    <= 1'b0;
            drop_count_r <= {DROP_COUNT_WIDTH{1'b0}};
        end else begin
            state_r   <= state_next_s;
            m_valid_r <= (state_next_s != ST_EMPTY);
            s_ready_r <= carrier_sel_s | (state_next_s != ST_FULL);
            if (drop_s && (drop_count_r != {DROP_COUNT_WIDTH{1'b1}})) begin
                drop_count_r <= drop_count_r + DROP_COUNT_WIDTH'(1);
            end
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        head_r <= beat_word_s;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        head_r <= beat_word_s;
                    end else if (in_fire_s) begin
                        skid_r <= beat_word_s;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        head_r <= skid_r;
                    end
                end
                default: begin
                    head_r <= head_r;
                end
            endcase
        end
    end

    assign S_AXIS_tready = s_ready_r;
    assign M_AXIS_tvalid = m_valid_r;
    assign M_AXIS_tdata  = head_r;
    assign drop_count    = drop_count_r;

endmodule

// File: tb/tb_fm_phase_mux.sv
// Bench for fm_phase_mux: a queue-based reference model predicts every beat
// entering the buffer; a monitor pops and compares whenever the DUT hands a
// beat to the master. Directed phases cover the documented scenarios and a
// random phase exercises arbitrary ready/valid patterns.
module tb_fm_phase_mux;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [1:0]  mode;
    logic [31:0] phase_carrier;
    logic [4:0]  dev_shift;
    logic        S_AXIS_tvalid;
    logic [15:0] S_AXIS_tdata;
    logic        S_AXIS_tready;
    logic        M_AXIS_tready;
    logic        M_AXIS_tvalid;
    logic [31:0] M_AXIS_tdata;
    logic [31:0] drop_count;

    always #5 aclk = ~aclk;

    fm_phase_mux #(
        .CARRIER_PINC_WIDTH(32),
        .SIGNAL_PHASE_WIDTH(16),
        .S_AXIS_TDATA_WIDTH(16),
        .M_AXIS_TDATA_WIDTH(32),
        .SHIFT_WIDTH(5),
        .DROP_COUNT_WIDTH(32)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .mode(mode),
        .phase_carrier(phase_carrier),
        .dev_shift(dev_shift),
        .S_AXIS_tvalid(S_AXIS_tvalid),
        .S_AXIS_tdata(S_AXIS_tdata),
        .S_AXIS_tready(S_AXIS_tready),
        .M_AXIS_tready(M_AXIS_tready),
        .M_AXIS_tvalid(M_AXIS_tvalid),
        .M_AXIS_tdata(M_AXIS_tdata),
        .drop_count(drop_count)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] out_log[$];
    int          occ = 0;
    bit          mready = 1'b0;
    logic [31:0] drop_exp = 32'd0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors < 60) $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic fail_bound(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired, got no handshake, want one", nm);
    endtask

    function automatic bit is_carrier(input logic [1:0] md);
        return (md != 2'd1) && (md != 2'd2);
    endfunction

    // Phase word straight from the arithmetic definition, in 64-bit integers.
    function automatic logic [31:0] ref_word(input logic [1:0] md, input logic [31:0] c,
                                             input logic [4:0] sh, input logic [15:0] d);
        longint sv;
        longint r;
        int     shv;
        sv  = longint'($signed(d));
        shv = (int'(sh) > 31) ? 31 : int'(sh);
        case (md)
            2'd1:    r = (sv + 64'sd32768) & 64'h0000_0000_0000_FFFF;
            2'd2:    r = (longint'(c) + sv * (64'sd1 <<< shv)) & 64'h0000_0000_FFFF_FFFF;
            default: r = longint'(c);
        endcase
        return r[31:0];
    endfunction

    // Reference: the buffer is a FIFO of capacity 2 fed per the mode rules.
    task automatic model_step();
        bit in_b;
        bit out_b;
        bit drop_b;
        if (!aresetn) begin
            occ      = 0;
            mready   = 1'b0;
            drop_exp = 32'd0;
            exp_q.delete();
        end else begin
            out_b = (occ > 0) && M_AXIS_tready;
            if (is_carrier(mode)) begin
                in_b   = mready && (occ < 2);
                drop_b = S_AXIS_tvalid && mready;
            end else begin
                in_b   = S_AXIS_tvalid && mready && (occ < 2);
                drop_b = S_AXIS_tvalid && mready && (occ == 2);
            end
            if (in_b) exp_q.push_back(ref_word(mode, phase_carrier, dev_shift, S_AXIS_tdata));
            if (drop_b && drop_exp != 32'hFFFF_FFFF) drop_exp = drop_exp + 32'd1;
            occ    = occ + (in_b ? 1 : 0) - (out_b ? 1 : 0);
            mready = is_carrier(mode) || (occ < 2);
        end
    endtask

    // Monitor: compare handshake state every cycle, pop on each master transfer.
    task automatic monitor_step();
        logic [31:0] exp;
        check("m_tvalid", 32'(M_AXIS_tvalid), 32'(occ > 0));
        check("s_tready", 32'(S_AXIS_tready), 32'(mready));
        check("drop_count", drop_count, drop_exp);
        if (aresetn && M_AXIS_tvalid && M_AXIS_tready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", M_AXIS_tdata, 32'hDEAD_BEEF);
            end else begin
                exp = exp_q.pop_front();
                check("sb_data", M_AXIS_tdata, exp);
            end
            out_log.push_back(M_AXIS_tdata);
        end
    endtask

    initial forever begin
        @(posedge aclk);
        model_step();
    end

    initial forever begin
        @(negedge aclk);
        monitor_step();
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic drain(input int n);
        S_AXIS_tvalid = 1'b0;
        M_AXIS_tready = 1'b1;
        repeat (n) next_cycle();
    endtask

    // Send one beat into an empty buffer and check it appears one cycle later.
    task automatic send_lat(input logic [15:0] d, input logic [31:0] exp, input string nm);
        bit ok;
        ok = 1'b0;
        S_AXIS_tdata  = d;
        S_AXIS_tvalid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge aclk);
            if (S_AXIS_tready) ok = 1'b1;
            else next_cycle();
        end
        if (!ok) begin
            fail_bound({nm, "_accept"});
            S_AXIS_tvalid = 1'b0;
        end else begin
            next_cycle();
            S_AXIS_tvalid = 1'b0;
            @(negedge aclk);
            check({nm, "_valid"}, 32'(M_AXIS_tvalid), 32'd1);
            check({nm, "_data"}, M_AXIS_tdata, exp);
            next_cycle();
        end
    endtask

    // Random traffic; beats counts slave handshakes (data modes) or master transfers (carrier).
    task automatic run_random(input int nbeats, input bit carrier_seg, input string nm);
        int beats;
        int cyc;
        bit hs;
        beats = 0;
        cyc   = 0;
        hs    = 1'b0;
        S_AXIS_tvalid = 1'b0;
        while (beats < nbeats && cyc < 40000) begin
            M_AXIS_tready = ($urandom_range(0, 3) != 0);
            if (carrier_seg) begin
                mode          = ($urandom_range(0, 1) != 0) ? 2'd0 : 2'd3;
                phase_carrier = $urandom;
                S_AXIS_tvalid = ($urandom_range(0, 1) != 0);
                S_AXIS_tdata  = 16'($urandom);
            end else begin
                mode          = 2'($urandom_range(1, 2));
                phase_carrier = $urandom;
                dev_shift     = 5'($urandom_range(0, 31));
                if (!S_AXIS_tvalid || hs) begin
                    S_AXIS_tvalid = ($urandom_range(0, 3) != 0);
                    S_AXIS_tdata  = 16'($urandom);
                end
            end
            @(negedge aclk);
            hs = S_AXIS_tvalid && S_AXIS_tready;
            if (carrier_seg) begin
                if (M_AXIS_tvalid && M_AXIS_tready) beats++;
            end else begin
                if (hs) beats++;
            end
            next_cycle();
            cyc++;
        end
        S_AXIS_tvalid = 1'b0;
        if (beats < nbeats) fail_bound(nm);
    endtask

    initial begin
        int stall_hs;
        bit hs;
        aresetn       = 1'b0;
        mode          = 2'd0;
        phase_carrier = 32'h0A3D_70A4;
        dev_shift     = 5'd0;
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tdata  = 16'h0000;
        M_AXIS_tready = 1'b1;

        // Reset values, then carrier start-up timing.
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_m_tvalid", 32'(M_AXIS_tvalid), 32'd0);
        check("rst_m_tdata", M_AXIS_tdata, 32'd0);
        check("rst_s_tready", 32'(S_AXIS_tready), 32'd0);
        next_cycle();
        aresetn = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        check("rel1_s_tready", 32'(S_AXIS_tready), 32'd1);
        check("rel1_m_tvalid", 32'(M_AXIS_tvalid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            check("carrier_tvalid", 32'(M_AXIS_tvalid), 32'd1);
            check("carrier_tdata", M_AXIS_tdata, 32'h0A3D_70A4);
        end
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            S_AXIS_tvalid = 1'b1;
            next_cycle();
            S_AXIS_tvalid = 1'b0;
            next_cycle();
        end
        @(negedge aclk);
        check("drop_count_5", drop_count, 32'd5);
        next_cycle();

        // Offset-binary passthrough.
        mode = 2'd1;
        drain(4);
        send_lat(16'h8000, 32'h0000_0000, "pass_8000");
        send_lat(16'h0000, 32'h0000_8000, "pass_0000");
        send_lat(16'h7FFF, 32'h0000_FFFF, "pass_7fff");

        // True FM.
        mode          = 2'd2;
        phase_carrier = 32'h1000_0000;
        dev_shift     = 5'd4;
        send_lat(16'h0001, 32'h1000_0010, "fm_pos1");
        send_lat(16'hFFFF, 32'h0FFF_FFF0, "fm_neg1");
        send_lat(16'h8000, 32'h0FF8_0000, "fm_min");

        // Wrap-around and the largest shift.
        phase_carrier = 32'hFFFF_FFF0;
        dev_shift     = 5'd0;
        send_lat(16'h0020, 32'h0000_0010, "fm_wrap");
        dev_shift     = 5'd31;
        send_lat(16'h0001, 32'h7FFF_FFF0, "fm_shift31");

        // Backpressure: 1 beat/cycle stream, master stalls for 6 cycles.
        phase_carrier = 32'h1000_0000;
        dev_shift     = 5'd4;
        drain(3);
        hs       = 1'b0;
        stall_hs = 0;
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = 16'($urandom);
        for (int c = 0; c < 20; c++) begin
            M_AXIS_tready = !(c >= 5 && c < 11);
            if (hs) S_AXIS_tdata = 16'($urandom);
            @(negedge aclk);
            hs = S_AXIS_tvalid && S_AXIS_tready;
            if (!M_AXIS_tready && hs) stall_hs++;
            if (c == 5) check("bp_s_tready_before_full", 32'(S_AXIS_tready), 32'd1);
            if (c == 6) check("bp_s_tready_after_full", 32'(S_AXIS_tready), 32'd0);
            if (c == 9) check("bp_m_tvalid_held", 32'(M_AXIS_tvalid), 32'd1);
            next_cycle();
        end
        S_AXIS_tvalid = 1'b0;
        check("bp_beats_held", 32'(1 + stall_hs), 32'd2);
        drain(4);

        // FULL in FM, then switch to carrier: both FM beats drain first.
        M_AXIS_tready = 1'b0;
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = 16'h0001;
        next_cycle();
        S_AXIS_tdata  = 16'hFFFF;
        next_cycle();
        S_AXIS_tvalid = 1'b0;
        mode          = 2'd0;
        phase_carrier = 32'h0A3D_70A4;
        out_log.delete();
        next_cycle();
        next_cycle();
        M_AXIS_tready = 1'b1;
        repeat (6) next_cycle();
        check("midop_log_len", 32'(out_log.size() >= 3), 32'd1);
        if (out_log.size() >= 3) begin
            check("midop_fm0", out_log[0], 32'h1000_0010);
            check("midop_fm1", out_log[1], 32'h0FFF_FFF0);
            check("midop_carrier", out_log[2], 32'h0A3D_70A4);
        end

        // Reset with the buffer FULL.
        mode          = 2'd2;
        phase_carrier = 32'h1000_0000;
        dev_shift     = 5'd4;
        drain(4);
        M_AXIS_tready = 1'b0;
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = 16'h1234;
        next_cycle();
        S_AXIS_tdata  = 16'h4321;
        next_cycle();
        S_AXIS_tvalid = 1'b0;
        @(negedge aclk);
        check("full_s_tready", 32'(S_AXIS_tready), 32'd0);
        next_cycle();
        aresetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check("rst2_m_tvalid", 32'(M_AXIS_tvalid), 32'd0);
        check("rst2_m_tdata", M_AXIS_tdata, 32'd0);
        check("rst2_s_tready", 32'(S_AXIS_tready), 32'd0);
        check("rst2_drop_count", drop_count, 32'd0);
        next_cycle();
        aresetn       = 1'b1;
        M_AXIS_tready = 1'b1;
        send_lat(16'h0001, 32'h1000_0010, "restart_fm");

        // Random carrier-mode traffic, then random data-mode traffic.
        run_random(300, 1'b1, "rand_carrier");
        mode = 2'd2;
        drain(4);
        run_random(10000, 1'b0, "rand_data");
        drain(6);
        check("sb_empty_at_end", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
